ex_alu_stage: RTL and testbench
===============================

# ex_alu_stage

Execute-stage ALU for the forwarding pipeline. It consumes the 5-bit ALU control code and 2-bit jump-register code from the ALU control decoder, along with forwarded operands. It computes the result and registers it into the EX/MEM boundary with valid/stall/flush control. It also raises a registered redirect for jr/jalr and a signed-overflow trap for add/sub.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ID/EX slot holds a live instruction
- stall  input  1  hold EX/MEM register; no state change
- flush  input  1  kill the instruction entering EX/MEM
- alu_ctr  input  5  ALU control code (1 add, 2 sub, 3 and, 4 or, 5 xor, 6 lui, 7 slt, 8 sltu, 9 nor, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav)
- jr  input  2  00 none, 01 jr, 10 jalr, 11 reserved (treated as none)
- ov_en  input  1  signed-overflow trap enabled (add/sub, addi); low for addu/subu/addiu
- op_a  input  32  forwarded rs value
- op_b  input  32  forwarded rt value or extended immediate
- shamt  input  5  instruction shift amount
- pc  input  32  PC of this instruction
- out_valid  output  1  EX/MEM slot live
- result  output  32  registered ALU result, or link address for jalr
- zero  output  1  registered (result == 0), computed on the ALU result before link substitution
- overflow  output  1  registered signed-overflow trap
- illegal  output  1  registered: alu_ctr is 0 or 16–31 with in_valid
- redirect  output  1  registered one-cycle pulse: jr/jalr taken
- redirect_pc  output  32  registered jump target

## Operation
- The combinational ALU core computes `r` from alu_ctr:
  - add/sub: `a ± b` mod 2^32.
  - and, or, xor, nor: bitwise.
  - lui: `b << 16`.
  - slt: signed compare, result 0 or 1. sltu: unsigned compare, result 0 or 1.
  - sll/srl/sra: shift `b` by shamt. sllv/srlv/srav: shift `b` by `a[4:0]`. sra and srav replicate `b[31]`.
- Overflow condition: `ov_en` and code is add or sub, with the operand-sign rule:
  - add: `a[31]==b[31]` and `r[31]!=a[31]`.
  - sub: `a[31]!=b[31]` and `r[31]!=a[31]`.
- On overflow, `result` is registered as 0. The destination write is suppressed downstream via `overflow`.
- Illegal code: `r = 0`, `illegal = 1`, `overflow = 0`, no redirect.
- jr = 01: `redirect = 1`, `redirect_pc = a`, `result = r` (don't-care downstream).
- jr = 10 (jalr): `redirect = 1`, `redirect_pc = a`, `result = pc + 8` (delay-slot link), zero from r.
- `redirect_pc` with `a[1:0] != 0` is passed through unchanged. Alignment is checked in IF.
- Register update priority each rising edge:
  1. `flush` (highest): `out_valid <= 0`; `redirect`, `overflow`, `illegal` <= 0; data regs <= 0.
  2. else `stall`: all registers hold, except `redirect`, which clears to 0 after one cycle. This prevents a repeated fetch redirect.
  3. else: `out_valid <= in_valid`. Data and flags load from the current inputs. Flags are gated by `in_valid`.
- When `in_valid = 0`, all flags register 0 and `result` registers 0.

## Timing
- Latency: 1 cycle from inputs to registered outputs. No combinational input→output paths.
- Reset (async assert, sync to clk on deassert by system): `out_valid = 0`, `result = 0`, `zero = 0`, `overflow = 0`, `illegal = 0`, `redirect = 0`, `redirect_pc = 0`.
- Reset mid-operation: all registers clear immediately. The in-flight instruction is lost and the first post-reset edge loads fresh inputs.
- `flush` and `stall` both high: flush wins.
- Back-to-back jr: each unstalled edge produces its own one-cycle redirect pulse. Consecutive pulses are legal.
- Shift amounts of 0 return `b` unchanged. sra by 31 yields all sign bits.
- add `0x7FFFFFFF + 1` with `ov_en = 0` gives `0x80000000` with no flag.

## Test plan
- **Reset:** assert `rst_n = 0` mid-cycle with `in_valid = 1` → all outputs 0 immediately. Release → the next edge loads `add 3 + 4` → `result = 7`, `out_valid = 1`, `zero = 0`.
- **Overflow:** add `0x7FFFFFFF + 1`, `ov_en = 1` → `overflow = 1`, `result = 0`. Same with `ov_en = 0` → `result = 0x80000000`, `overflow = 0`. Sub `0x80000000 − 1`, `ov_en = 1` → `overflow = 1`.
- **Shifts and compares:**
  - sra `b = 0x80000000`, shamt 31 → `0xFFFFFFFF`.
  - srav `a = 0x24`, `b = 0xF0` → `0x0F` (uses `a[4:0] = 4`).
  - slt `a = −1`, `b = 1` → 1. sltu same operands → 0.
  - lui `b = 0x1234` → `0x12340000`.
- **jalr:** `pc = 0x00400010`, `a = 0x00400100`, `jr = 10` → `redirect = 1` for exactly one cycle, `redirect_pc = 0x00400100`, `result = 0x00400018`.
- **Stall/flush:**
  - Load sub 5 − 5 (`zero = 1`), then hold `stall = 1` for 3 cycles with changing inputs → outputs stable, `zero = 1`.
  - Jr followed by stall → redirect high 1 cycle only.
  - `stall = 1` and `flush = 1` together → `out_valid = 0`.
- **Illegal/idle:** `alu_ctr = 0` with `in_valid = 1` → `illegal = 1`, `result = 0`. `alu_ctr = 20` with `in_valid = 0` → `illegal = 0`, `out_valid = 0`.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU: computes the ALU result, overflow trap and jr/jalr redirect,
// and registers them into the EX/MEM boundary under stall/flush control.
module ex_alu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  alu_ctr,
    input  logic [1:0]  jr,
    input  logic        ov_en,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  shamt,
    input  logic [31:0] pc,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_LUI  = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
    localparam logic [4:0] ALU_SLTU = 5'd8;
    localparam logic [4:0] ALU_NOR  = 5'd9;
    localparam logic [4:0] ALU_SLL  = 5'd10;
    localparam logic [4:0] ALU_SRL  = 5'd11;
    localparam logic [4:0] ALU_SRA  = 5'd12;
    localparam logic [4:0] ALU_SLLV = 5'd13;
    localparam logic [4:0] ALU_SRLV = 5'd14;
    localparam logic [4:0] ALU_SRAV = 5'd15;

    localparam logic [1:0] JR_JR   = 2'b01;
    localparam logic [1:0] JR_JALR = 2'b10;

    // Slot semantics: out_valid marks a live EX/MEM entry. It follows in_valid on
    // every unstalled edge, holds under stall, and is killed by flush (flush wins).
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        overflow_q, overflow_d;
    logic        illegal_q, illegal_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [31:0] sum, diff, alu_r, link_pc;
    logic        code_ok, ov_add, ov_sub, ov_hit, jump_taken;

    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign link_pc = pc + 32'd8;

    always_comb begin
        alu_r   = '0;
        code_ok = 1'b1;
        case (alu_ctr)
            ALU_ADD:  alu_r = sum;
            ALU_SUB:  alu_r = diff;
            ALU_AND:  alu_r = op_a & op_b;
            ALU_OR:   alu_r = op_a | op_b;
            ALU_XOR:  alu_r = op_a ^ op_b;
            ALU_LUI:  alu_r = {op_b[15:0], 16'h0000};
            ALU_SLT:  alu_r = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_r = {31'b0, op_a < op_b};
            ALU_NOR:  alu_r = ~(op_a | op_b);
            ALU_SLL:  alu_r = op_b << shamt;
            ALU_SRL:  alu_r = op_b >> shamt;
            ALU_SRA:  alu_r = $signed(op_b) >>> shamt;
            ALU_SLLV: alu_r = op_b << op_a[4:0];
            ALU_SRLV: alu_r = op_b >> op_a[4:0];
            ALU_SRAV: alu_r = $signed(op_b) >>> op_a[4:0];
            default: begin
                alu_r   = '0;
                code_ok = 1'b0;
            end
        endcase
    end

    // Signed overflow from operand/result sign bits; sub overflows only on mixed signs.
    assign ov_add = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
    assign ov_sub = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);

    always_comb begin
        ov_hit = 1'b0;
        if (in_valid && code_ok && ov_en) begin
            if (alu_ctr == ALU_ADD) ov_hit = ov_add;
            else if (alu_ctr == ALU_SUB) ov_hit = ov_sub;
        end
    end

    // jr code 11 is reserved and behaves as no jump.
    assign jump_taken = in_valid && code_ok && ((jr == JR_JR) || (jr == JR_JALR));

    always_comb begin
        out_valid_d   = in_valid;
        illegal_d     = in_valid && !code_ok;
        overflow_d    = ov_hit;
        zero_d        = in_valid && (alu_r == 32'd0);
        redirect_d    = jump_taken;
        redirect_pc_d = jump_taken ? op_a : 32'd0;
        if (!in_valid || !code_ok || ov_hit) begin
            result_d = 32'd0;
        end else if (jr == JR_JALR) begin
            result_d = link_pc;
        end else begin
            result_d = alu_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            zero_q        <= 1'b0;
            overflow_q    <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (flush) begin
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            zero_q        <= 1'b0;
            overflow_q    <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (stall) begin
            // Redirect is a pulse: a held slot must not re-steer fetch.
            redirect_q    <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
            overflow_q    <= overflow_d;
            illegal_q     <= illegal_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = overflow_q;
    assign illegal     = illegal_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed and randomized checks of ex_alu_stage against an arithmetic reference model.
module tb_ex_alu_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  alu_ctr;
    logic [1:0]  jr;
    logic        ov_en;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] pc;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    logic        e_valid, e_zero, e_ov, e_ill, e_red;
    logic [31:0] e_res, e_rpc;

    ex_alu_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_ctr(alu_ctr), .jr(jr), .ov_en(ov_en), .op_a(op_a), .op_b(op_b),
        .shamt(shamt), .pc(pc), .out_valid(out_valid), .result(result), .zero(zero),
        .overflow(overflow), .illegal(illegal), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sra(input logic [31:0] b, input int s);
        logic [31:0] fill;
        fill = 32'hFFFF_FFFF;
        return (b >> s) | (b[31] ? ~(fill >> s) : 32'd0);
    endfunction

    function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a,
                                            input logic [31:0] b, input int sh);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            1:  return a + b;
            2:  return a - b;
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return b * 32'h0001_0000;
            7:  return (sa < sb) ? 32'd1 : 32'd0;
            8:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            9:  return ~(a | b);
            10: return b << sh;
            11: return b >> sh;
            12: return ref_sra(b, sh);
            13: return b << (a % 32);
            14: return b >> (a % 32);
            15: return ref_sra(b, int'(a % 32));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input int code, input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (code == 1) s = longint'($signed(a)) + longint'($signed(b));
        else if (code == 2) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic model_clear();
        e_valid = 0; e_zero = 0; e_ov = 0; e_ill = 0; e_red = 0; e_res = 0; e_rpc = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
        chk({tag, ".result"}, result, e_res);
        if (!e_ov) chk({tag, ".zero"}, {31'b0, zero}, {31'b0, e_zero});
        chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, e_ov});
        chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e_ill});
        chk({tag, ".redirect"}, {31'b0, redirect}, {31'b0, e_red});
        if (e_red) chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
    endtask

    // Drive one cycle of inputs, advance the model for that edge, then compare.
    task automatic step(input string tag, input logic iv, input logic st, input logic fl,
                        input logic [4:0] ctr, input logic [1:0] j, input logic ov,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] p);
        logic        ok, ovf, take;
        logic [31:0] r;
        @(negedge clk);
        in_valid = iv; stall = st; flush = fl; alu_ctr = ctr; jr = j; ov_en = ov;
        op_a = a; op_b = b; shamt = sh; pc = p;
        ok   = (ctr >= 1) && (ctr <= 15);
        r    = ok ? ref_alu(int'(ctr), a, b, int'(sh)) : 32'd0;
        ovf  = iv && ok && ov && ref_ovf(int'(ctr), a, b);
        take = iv && ok && (j == 2'b01 || j == 2'b10);
        if (fl) begin
            model_clear();
        end else if (st) begin
            e_red = 0;
        end else begin
            e_valid = iv;
            e_ill   = iv && !ok;
            e_ov    = ovf;
            e_red   = take;
            e_rpc   = take ? a : 32'd0;
            e_zero  = iv && (r == 32'd0);
            e_res   = (!iv || !ok || ovf) ? 32'd0 : ((j == 2'b10) ? p + 32'd8 : r);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; stall = 0; flush = 0; alu_ctr = 0; jr = 0; ov_en = 0;
        op_a = 0; op_b = 0; shamt = 0; pc = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_init");
        chk("reset_init.redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1;

        step("pre_rst", 1, 0, 0, 5'd4, 2'b00, 0, 32'h00F0, 32'h0F00, 5'd0, 32'h0);
        chk("pre_rst.or", result, 32'h0FF0);
        #2;
        in_valid = 1;
        rst_n = 0;
        #1;
        model_clear();
        check_all("async_rst");
        chk("async_rst.redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1;
        step("post_rst_add", 1, 0, 0, 5'd1, 2'b00, 0, 32'd3, 32'd4, 5'd0, 32'h0);
        chk("post_rst_add.k", result, 32'd7);
        chk("post_rst_add.k_valid", {31'b0, out_valid}, 32'd1);

        step("add_ovf", 1, 0, 0, 5'd1, 2'b00, 1, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h0);
        chk("add_ovf.k_flag", {31'b0, overflow}, 32'd1);
        chk("add_ovf.k_res", result, 32'd0);
        step("addu_wrap", 1, 0, 0, 5'd1, 2'b00, 0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h0);
        chk("addu_wrap.k_res", result, 32'h8000_0000);
        chk("addu_wrap.k_flag", {31'b0, overflow}, 32'd0);
        step("sub_ovf", 1, 0, 0, 5'd2, 2'b00, 1, 32'h8000_0000, 32'd1, 5'd0, 32'h0);
        chk("sub_ovf.k_flag", {31'b0, overflow}, 32'd1);

        step("sra31", 1, 0, 0, 5'd12, 2'b00, 0, 32'h0, 32'h8000_0000, 5'd31, 32'h0);
        chk("sra31.k", result, 32'hFFFF_FFFF);
        step("srav", 1, 0, 0, 5'd15, 2'b00, 0, 32'h24, 32'hF0, 5'd0, 32'h0);
        chk("srav.k", result, 32'h0F);
        step("slt", 1, 0, 0, 5'd7, 2'b00, 0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0);
        chk("slt.k", result, 32'd1);
        step("sltu", 1, 0, 0, 5'd8, 2'b00, 0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0);
        chk("sltu.k", result, 32'd0);
        step("lui", 1, 0, 0, 5'd6, 2'b00, 0, 32'h0, 32'h1234, 5'd0, 32'h0);
        chk("lui.k", result, 32'h1234_0000);
        step("sll0", 1, 0, 0, 5'd10, 2'b00, 0, 32'h0, 32'hA5A5_0F0F, 5'd0, 32'h0);
        chk("sll0.k", result, 32'hA5A5_0F0F);

        step("jalr", 1, 0, 0, 5'd1, 2'b10, 0, 32'h0040_0100, 32'h0, 5'd0, 32'h0040_0010);
        chk("jalr.k_red", {31'b0, redirect}, 32'd1);
        chk("jalr.k_pc", redirect_pc, 32'h0040_0100);
        chk("jalr.k_link", result, 32'h0040_0018);
        step("jalr_next", 0, 0, 0, 5'd1, 2'b00, 0, 32'h0, 32'h0, 5'd0, 32'h0);
        chk("jalr_next.k_red", {31'b0, redirect}, 32'd0);

        step("sub_zero", 1, 0, 0, 5'd2, 2'b00, 0, 32'd5, 32'd5, 5'd0, 32'h0);
        chk("sub_zero.k", {31'b0, zero}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1, 1, 0, 5'($urandom_range(1, 15)), 2'b01, 0,
                 $urandom(), $urandom(), 5'($urandom_range(0, 31)), $urandom());
            chk("stall_hold.k_zero", {31'b0, zero}, 32'd1);
            chk("stall_hold.k_valid", {31'b0, out_valid}, 32'd1);
        end

        step("jr_a", 1, 0, 0, 5'd3, 2'b01, 0, 32'h0000_1002, 32'h0, 5'd0, 32'h0);
        step("jr_b", 1, 0, 0, 5'd3, 2'b01, 0, 32'h0000_2000, 32'h0, 5'd0, 32'h0);
        chk("jr_b.k_red", {31'b0, redirect}, 32'd1);
        step("jr_stall", 1, 1, 0, 5'd3, 2'b01, 0, 32'h0000_3000, 32'h0, 5'd0, 32'h0);
        chk("jr_stall.k_red", {31'b0, redirect}, 32'd0);
        step("stall_flush", 1, 1, 1, 5'd1, 2'b00, 0, 32'd1, 32'd1, 5'd0, 32'h0);
        chk("stall_flush.k", {31'b0, out_valid}, 32'd0);

        step("illegal0", 1, 0, 0, 5'd0, 2'b00, 0, 32'd9, 32'd9, 5'd0, 32'h0);
        chk("illegal0.k_ill", {31'b0, illegal}, 32'd1);
        chk("illegal0.k_res", result, 32'd0);
        step("idle20", 0, 0, 0, 5'd20, 2'b00, 0, 32'd9, 32'd9, 5'd0, 32'h0);
        chk("idle20.k_ill", {31'b0, illegal}, 32'd0);
        chk("idle20.k_valid", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [4:0]  c;
            logic [1:0]  j;
            logic [31:0] a, b;
            logic        o;
            c = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(1, 15));
            j = 2'($urandom_range(0, 3));
            o = (j == 2'b01 || j == 2'b10) ? 1'b0 : 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom();
            b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
            if ($urandom_range(0, 7) == 0) b = a;
            step("rand", 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 15) == 0), c, j, o, a, b,
                 5'($urandom_range(0, 31)), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
